keypad_scanner: RTL and testbench

- Upstream stage of the keypad path: scans a 4x4 membrane keypad one column at a time and synchronizes the row inputs.
- Resolves the pressed key to a 4-bit hex code and presents `key_code`/`key_pressed` to the debouncer.
- Performs no debouncing itself. It only locks onto a key and holds the scan on that key's column until release.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_scanner_sync2.sv | 31 +++
 rtl/keypad_scanner.sv | 111 +++++++++++
 tb/tb_keypad_scanner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types, dimensions and keymap helpers, also used by the display decoder.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned MAP_W    = NUM_ROWS * NUM_COLS * CODE_W;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_t;

  // Entry {row,col} lives at bits [4*{row,col} +: 4]; rows read 123A / 456B / 789C / E0FD.
  localparam logic [MAP_W-1:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [CODE_W-1:0] keymap(input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
    return KEYMAP[{row, col, 2'b00} +: CODE_W];
  endfunction

  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] row_s);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (!row_s[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [NUM_ROWS-1:0] row_s);
    return $countones(~row_s) > 1;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer with all-ones reset, for pulled-up active-low inputs.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: locks onto a pressed key and holds its column until release.
// Optional macro KEYPAD_GHOST_REJECT_EN treats multiple low rows in a column as no key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4800
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_pressed
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 4");
  end

  logic [NUM_ROWS-1:0] row_s;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (row_s)
  );

  scan_state_t         state_d, state_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [COL_W-1:0]    col_idx_d, col_idx_q;
  logic [ROW_W-1:0]    row_idx_d, row_idx_q;
  logic [NUM_COLS-1:0] col_n_d, col_n_q;
  logic [CODE_W-1:0]   key_code_d, key_code_q;
  logic                key_pressed_d, key_pressed_q;

  logic                dwell_end_c;
  logic                ghost_c;
  logic [ROW_W-1:0]    lock_row_c;

  // Next-state: sample rows only at the end of each column dwell.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;

    dwell_end_c = (cnt_q == CNT_MAX);
    cnt_d       = dwell_end_c ? '0 : cnt_q + 1'b1;
    lock_row_c  = lowest_low_row(row_s);
`ifdef KEYPAD_GHOST_REJECT_EN
    ghost_c     = multi_low(row_s);
`else
    ghost_c     = 1'b0;
`endif

    unique case (state_q)
      SCAN: begin
        if (dwell_end_c) begin
          if ((&row_s) || ghost_c) begin
            col_idx_d = col_idx_q + 1'b1;
          end else begin
            state_d       = HOLD;
            row_idx_d     = lock_row_c;
            key_code_d    = keymap(lock_row_c, col_idx_q);
            key_pressed_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (dwell_end_c && (row_s[row_idx_q] || ghost_c)) begin
          state_d       = SCAN;
          key_pressed_d = 1'b0;
          col_idx_d     = col_idx_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase

    col_n_d = ~(NUM_COLS'(1) << col_idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      col_n_q       <= 4'b1110;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      col_n_q       <= col_n_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign col_n       = col_n_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated keypad matrix, directed vector table and a random run vs a scan model.
module tb_keypad_scanner;

  localparam int SD = 8;
`ifdef KEYPAD_GHOST_REJECT_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_pressed;

  // Pressed keys: bit r*4+c is the key at row r, column c.
  logic [15:0] keys;

  keypad_scanner #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // Membrane matrix: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  int n_checks = 0;
  int n_fail   = 0;

  int km [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  // Reference scan model
  logic [15:0] hist[$];
  int   t;
  int   m_col;
  int   m_row;
  bit   m_locked;
  int   m_code;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] smp;
    logic [3:0]  ck;
    int          n;
    if (reset) begin
      t = 0; m_col = 0; m_row = 0; m_locked = 0; m_code = 0;
      hist.push_back(16'h0);
    end else begin
      hist.push_back(keys);
      t++;
      if (t % SD == 0) begin
        // Rows seen at this sample were on the pins two edges earlier.
        smp = hist[hist.size()-3];
        for (int r = 0; r < 4; r++) ck[r] = smp[r*4 + m_col];
        n = $countones(ck);
        if (!m_locked) begin
          if (n == 0 || (GHOST && n > 1)) begin
            m_col = (m_col + 1) % 4;
          end else begin
            m_row = 3;
            for (int r = 3; r >= 0; r--) if (ck[r]) m_row = r;
            m_code   = km[m_row][m_col];
            m_locked = 1;
          end
        end else if (!ck[m_row] || (GHOST && n > 1)) begin
          m_locked = 0;
          m_col    = (m_col + 1) % 4;
        end
      end
    end
    while (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_col_n", col_n, ~(4'b0001 << m_col));
    chk("model_key_pressed", {3'b0, key_pressed}, {3'b0, m_locked});
    chk("model_key_code", key_code, 4'(m_code));
  endtask

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    logic        exp_pressed;
    logic [3:0]  exp_code;
    bit          chk_col;
    logic [3:0]  exp_col;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h0000, 40, 1'b0, 4'h0, 1'b0, 4'hF};
    vecs[1] = '{16'h0040, 40, 1'b1, 4'h6, 1'b1, 4'b1011};
    vecs[2] = '{16'h0000, 16, 1'b0, 4'h6, 1'b0, 4'hF};
    vecs[3] = '{16'h0020, 40, 1'b1, 4'h5, 1'b1, 4'b1101};
    vecs[4] = '{16'h0420, 40, 1'b1, 4'h5, 1'b1, 4'b1101};
    vecs[5] = '{16'h0400, 40, 1'b1, 4'h9, 1'b1, 4'b1011};
    vecs[6] = '{16'h0000, 16, 1'b0, 4'h9, 1'b0, 4'hF};
    if (GHOST) vecs[7] = '{16'h2002, 40, 1'b0, 4'h9, 1'b0, 4'hF};
    else       vecs[7] = '{16'h2002, 40, 1'b1, 4'h2, 1'b1, 4'b1101};
    vecs[8] = '{16'h0000, 16, 1'b0, (GHOST ? 4'h9 : 4'h2), 1'b0, 4'hF};
    vecs[9] = '{16'h8000, 40, 1'b1, 4'hD, 1'b1, 4'b0111};

    for (int i = 0; i < 3; i++) hist.push_back(16'h0);
    keys  = 16'h0;
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("reset_col_n", col_n, 4'b1110);
    chk("reset_key_code", key_code, 4'h0);
    chk("reset_key_pressed", {3'b0, key_pressed}, 4'h0);
    reset = 1'b0;

    // Idle scan: each column low for exactly SD cycles, in order.
    for (int e = 1; e <= 4*SD + 1; e++) begin
      tick();
      chk("idle_col_n", col_n, ~(4'b0001 << ((e / SD) % 4)));
      chk("idle_key_pressed", {3'b0, key_pressed}, 4'h0);
    end

    for (int i = 0; i < 10; i++) begin
      keys = vecs[i].keys;
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      chk($sformatf("vec%0d_key_pressed", i), {3'b0, key_pressed}, {3'b0, vecs[i].exp_pressed});
      chk($sformatf("vec%0d_key_code", i), key_code, vecs[i].exp_code);
      if (vecs[i].chk_col) chk($sformatf("vec%0d_col_n", i), col_n, vecs[i].exp_col);
    end

    // Reset while locked on D takes effect on the very next edge.
    reset = 1'b1;
    tick();
    chk("midhold_reset_key_pressed", {3'b0, key_pressed}, 4'h0);
    chk("midhold_reset_key_code", key_code, 4'h0);
    chk("midhold_reset_col_n", col_n, 4'b1110);
    reset = 1'b0;
    keys  = 16'h0;
    for (int c = 0; c < 4; c++) tick();

    // Random presses: none, single or double keys, various hold times.
    for (int it = 0; it < 200; it++) begin
      int sel;
      int hold;
      sel  = int'($urandom_range(0, 9));
      keys = 16'h0;
      if (sel >= 3) keys[$urandom_range(0, 15)] = 1'b1;
      if (sel >= 8) keys[$urandom_range(0, 15)] = 1'b1;
      hold = int'($urandom_range(1, 50));
      for (int c = 0; c < hold; c++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
